sar_conv_ctrl: RTL and testbench
================================

// Module: sar_conv_ctrl
// PURPOSE
// Conversion sequencer on the SAR core's control side. Runs the sample phase and
// asserts En for the bit-decision phase. Counts comparator decisions (Op|Om) and
// captures the SAR's D word after NBITS decisions. Hands each result to the EEG
// back end over a valid/ready port. Single-shot (start) or continuous (cont) mode.
// PARAMETERS
// NBITS        8   decisions per conversion; width of d_in/dout
// SAMPLE_CYC   4   clk cycles sample is high before En rises (>=1)
// TIMEOUT_CYC  32  max clk cycles in CONVERT before abort (>NBITS)
// PORTS
// clk        in   1      system clock, all logic posedge
// rst        in   1      asynchronous, active-high reset
// start      in   1      1-cycle pulse: begin one conversion (ignored unless IDLE)
// cont       in   1      level: back-to-back conversions while high
// Op         in   1      comparator "plus" decision strobe from SAR front end
// Om         in   1      comparator "minus" decision strobe
// d_in       in   NBITS  SAR result word D
// En         out  1      SAR enable; low clears SAR counter/B/BN/D
// sample     out  1      sampling-switch control, high during SAMPLE only
// busy       out  1      high in every state except IDLE
// dout       out  NBITS  captured result, stable while dout_valid=1
// dout_valid out  1      result available
// dout_ready in   1      consumer accepts when dout_valid&dout_ready at posedge
// overrun    out  1      sticky: result dropped, previous not yet consumed
// timeout    out  1      sticky: CONVERT exceeded TIMEOUT_CYC
// clr_flags  in   1      sync clear of overrun/timeout (set wins if same cycle)
// BEHAVIOUR
// - Reset (async): state=IDLE, En=0, sample=0, busy=0, dout=0, dout_valid=0,
//   overrun=0, timeout=0, dcnt=0, cyc=0. All outputs registered.
// - FSM: IDLE -> SAMPLE -> CONVERT -> CAPTURE -> RECOVER -> (SAMPLE|IDLE).
// - IDLE: En=0, sample=0. Exit to SAMPLE on start=1 or cont=1.
// - SAMPLE: sample=1, En=0, exactly SAMPLE_CYC cycles, then CONVERT.
// - CONVERT: En=1, sample=0. dcnt+1 each posedge with (Op|Om)=1; Op&Om=1 counts once.
//   dcnt==NBITS -> CAPTURE. cyc reaching TIMEOUT_CYC first -> timeout<=1, RECOVER, no result.
// - CAPTURE (1 cycle, En=1 so D held): if !dout_valid or (dout_valid&dout_ready):
//   dout<=d_in, dout_valid<=1. Else overrun<=1; old dout/dout_valid kept.
// - RECOVER (1 cycle): En=0 so SAR clears; dcnt, cyc <= 0. Next SAMPLE if cont=1, else IDLE.
// - Latency: decision NBITS at edge k -> dout_valid high after edge k+1.
//   Sample start to next sample start in cont mode = SAMPLE_CYC+NBITS+2 min.
// - Handshake: dout_valid drops on the edge where dout_ready=1, unless a new
//   capture loads in the same edge (valid stays 1, new dout). ready w/o valid ignored.
// - start while busy ignored; cont dropped mid-conversion finishes current, then IDLE.
// - rst mid-conversion: immediate async return to reset values, En=0.
// - Counters sized clog2(NBITS+1) / clog2(TIMEOUT_CYC+1); no wrap possible.
// TESTING
// - Single shot: start pulse, 8 Op/Om strobes, d_in=8'hA5 -> sample high 4 cycles, En high,
//   dout=8'hA5, dout_valid=1 one edge after 8th strobe, then En=0 one cycle, IDLE.
// - Backpressure: cont=1, dout_ready=0, 2 conversions (8'h11, 8'h22) -> dout stays 8'h11,
//   overrun=1; clr_flags -> overrun=0.
// - Same-edge accept+capture: dout_ready=1 on CAPTURE edge -> dout=new word, valid stays 1,
//   no overrun.
// - Timeout: start, only 5 strobes -> after 32 CONVERT cycles timeout=1, dout_valid unchanged, IDLE.
// - Op&Om both high on one cycle -> counted once; 8 such cycles finish conversion.
// - rst asserted mid-CONVERT (dcnt=3) -> all outputs at reset values; restart converts cleanly.

Source files
------------

// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl: control-side sequencer for a SAR ADC core.
// It runs a timed sample phase and then enables the SAR for the bit decisions.
// It counts comparator strobes (Op|Om) and captures the D word once NBITS decisions
// have been made. Each result goes to the back end over a valid/ready port.
// Conversions run single-shot (start) or back-to-back (cont).
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   start, cont              single-shot pulse / continuous-mode level
//   Op, Om, d_in             comparator strobes and SAR result word
//   En, sample, busy         SAR enable, sampling switch, sequencer-active (all registered)
//   dout, dout_valid,
//   dout_ready               result port (valid/ready)
//   overrun, timeout,
//   clr_flags                sticky error flags and their synchronous clear
module sar_conv_ctrl #(
  parameter int NBITS       = 8,
  parameter int SAMPLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             Op,
  input  logic             Om,
  input  logic [NBITS-1:0] d_in,
  output logic             En,
  output logic             sample,
  output logic             busy,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             timeout,
  input  logic             clr_flags
);

  localparam int DW = $clog2(NBITS + 1);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SAMPLE  = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_inc;
  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_inc;
  logic [SW-1:0] scnt;
  logic          decision;
  logic          conv_done;
  logic          conv_abort;
  logic          cap_load;
  logic          cap_drop;
  logic          accept;

  // A cycle with both strobes high is still a single decision.
  assign decision = Op | Om;
  assign dcnt_inc = dcnt + DW'(decision);
  assign cyc_inc  = cyc + CW'(1);

  // The last decision wins over the timeout when both land on the same edge.
  assign conv_done  = (state == S_CONVERT) && (dcnt_inc == DW'(NBITS));
  assign conv_abort = (state == S_CONVERT) && !conv_done && (cyc_inc == CW'(TIMEOUT_CYC));

  // A capture may load when the output register is free or is being emptied on
  // this very edge; otherwise the new word is dropped and flagged.
  assign accept   = dout_valid && dout_ready;
  assign cap_load = (state == S_CAPTURE) && (!dout_valid || dout_ready);
  assign cap_drop = (state == S_CAPTURE) && dout_valid && !dout_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start || cont) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (scnt == SW'(SAMPLE_CYC - 1)) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        if (conv_done)       state_nxt = S_CAPTURE;
        else if (conv_abort) state_nxt = S_RECOVER;
      end
      S_CAPTURE: begin
        state_nxt = S_RECOVER;
      end
      S_RECOVER: begin
        state_nxt = cont ? S_SAMPLE : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and the phase outputs are registered together from the next state,
  // so En/sample/busy change on the same edge as the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      En     <= 1'b0;
      sample <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      // En stays high through CAPTURE so the SAR keeps D stable while it is loaded.
      En     <= (state_nxt == S_CONVERT) || (state_nxt == S_CAPTURE);
      sample <= (state_nxt == S_SAMPLE);
      busy   <= (state_nxt != S_IDLE);
    end
  end

  // Sample-phase length counter; it only runs while staying in SAMPLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
    end else if ((state == S_SAMPLE) && (state_nxt == S_SAMPLE)) begin
      scnt <= scnt + SW'(1);
    end else begin
      scnt <= '0;
    end
  end

  // Decision and CONVERT-cycle counters. They count only in CONVERT and clear in
  // RECOVER, so neither can pass NBITS / TIMEOUT_CYC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= '0;
      cyc  <= '0;
    end else if (state == S_CONVERT) begin
      dcnt <= dcnt_inc;
      cyc  <= cyc_inc;
    end else if (state == S_RECOVER) begin
      dcnt <= '0;
      cyc  <= '0;
    end
  end

  // Result register. A load on the same edge as an accept keeps valid high
  // with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (cap_load) begin
      dout       <= d_in;
      dout_valid <= 1'b1;
    end else if (accept) begin
      dout_valid <= 1'b0;
    end
  end

  // Sticky flags: a set event beats a clear on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (cap_drop)       overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;
      if (conv_abort)     timeout <= 1'b1;
      else if (clr_flags) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Directed bench for sar_conv_ctrl with hand-computed expectations.
// Inputs are driven 1 ns after the rising edge and outputs are checked there as well.
module tb_sar_conv_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       Op = 1'b0;
  logic       Om = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       En;
  logic       sample;
  logic       busy;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       overrun;
  logic       timeout;
  logic       clr_flags = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sar_conv_ctrl #(.NBITS(8), .SAMPLE_CYC(4), .TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .Op(Op), .Om(Om),
    .d_in(d_in), .En(En), .sample(sample), .busy(busy), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .overrun(overrun),
    .timeout(timeout), .clr_flags(clr_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for En to rise (covers the whole sample phase).
  task automatic wait_en(input string tag);
    for (int i = 0; i < 20 && !En; i++) tick();
    chk(tag, En, 1);
  endtask

  // n decision cycles with word w presented on d_in; both=1 raises Op and Om together.
  task automatic strobes(input int n, input logic both, input logic [7:0] w);
    d_in = w;
    for (int i = 0; i < n; i++) begin
      Op = 1'b1;
      Om = both;
      tick();
    end
    Op = 1'b0;
    Om = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state.
    repeat (2) tick();
    chk("rst_en", En, 0);
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_flags", {overrun, timeout}, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Single shot, 0xA5.
    pulse_start();
    chk("ss_sample", sample, 1);
    chk("ss_busy", busy, 1);
    chk("ss_en_low", En, 0);
    n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sample) n++;
      else break;
    end
    chk("ss_sample_len", n, 4);
    chk("ss_en_high", En, 1);
    strobes(8, 1'b0, 8'hA5);
    chk("ss_capture_en", En, 1);
    chk("ss_valid_pre", dout_valid, 0);
    tick();
    chk("ss_valid", dout_valid, 1);
    chk("ss_dout", dout, 8'hA5);
    chk("ss_recover_en", En, 0);
    tick();
    chk("ss_idle", busy, 0);

    // Consume the result.
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("accept_drop", dout_valid, 0);

    // Backpressure in continuous mode: 0x11 then 0x22 while ready is low.
    cont = 1'b1;
    wait_en("bp_en1");
    strobes(8, 1'b0, 8'h11);
    tick();
    chk("bp_dout1", dout, 8'h11);
    chk("bp_valid1", dout_valid, 1);
    tick();
    chk("bp_resample", sample, 1);
    wait_en("bp_en2");
    cont = 1'b0;
    strobes(8, 1'b0, 8'h22);
    tick();
    chk("bp_overrun", overrun, 1);
    chk("bp_dout_kept", dout, 8'h11);
    chk("bp_valid_kept", dout_valid, 1);
    tick();
    chk("bp_idle", busy, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("bp_clr", overrun, 0);

    // Accept and capture on the same edge.
    pulse_start();
    wait_en("se_en");
    strobes(8, 1'b0, 8'h33);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("se_dout", dout, 8'h33);
    chk("se_valid", dout_valid, 1);
    chk("se_no_overrun", overrun, 0);
    tick();

    // Timeout after 32 CONVERT cycles with only 5 strobes.
    pulse_start();
    wait_en("to_en");
    strobes(5, 1'b0, 8'h77);
    repeat (26) tick();
    chk("to_not_yet", timeout, 0);
    chk("to_en_31", En, 1);
    tick();
    chk("to_flag", timeout, 1);
    chk("to_en_low", En, 0);
    chk("to_valid_kept", dout_valid, 1);
    chk("to_dout_kept", dout, 8'h33);
    tick();
    chk("to_idle", busy, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("to_clr", timeout, 0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Op and Om together count once.
    pulse_start();
    wait_en("both_en");
    strobes(7, 1'b1, 8'h5A);
    chk("both_7_running", En, 1);
    chk("both_7_no_valid", dout_valid, 0);
    strobes(1, 1'b1, 8'h5A);
    chk("both_8_capture", dout_valid, 0);
    tick();
    chk("both_valid", dout_valid, 1);
    chk("both_dout", dout, 8'h5A);
    tick();

    // Asynchronous reset mid-CONVERT after 3 decisions.
    pulse_start();
    wait_en("mr_en");
    strobes(3, 1'b0, 8'h99);
    rst = 1'b1;
    #2;
    chk("mr_en", En, 0);
    chk("mr_busy", busy, 0);
    chk("mr_sample", sample, 0);
    chk("mr_dout", dout, 0);
    chk("mr_valid", dout_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    wait_en("mr2_en");
    strobes(8, 1'b0, 8'hC3);
    tick();
    chk("mr2_dout", dout, 8'hC3);
    chk("mr2_valid", dout_valid, 1);
    chk("mr2_flags", {overrun, timeout}, 0);
    tick();
    chk("mr2_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
